branch_predict_resolve: RTL and testbench

- Sits directly downstream of the execute-stage branch comparator and consumes its taken/not-taken result.
- Holds a bimodal branch history table (BHT) of 2-bit saturating counters.
  - Fetch reads it for a prediction.
  - Execute writes it with the resolved outcome.
- Compares each resolved outcome with the prediction carried down the pipe, and issues a registered one-cycle flush/redirect on mispredict.

---
 rtl/branch_predict_resolve_pkg.sv | 32 +++
 rtl/branch_predict_resolve_if.sv | 38 +++
 rtl/bp_sat_counter2.sv | 19 +
 rtl/branch_predict_resolve.sv | 98 +++++++++
 tb/tb_branch_predict_resolve.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/branch_predict_resolve_pkg.sv
// rtl/branch_predict_resolve_pkg.sv - shared opcodes, counter and FSM encodings for the branch predictor
package branch_predict_resolve_pkg;

  localparam int BP_IDX_BITS = 6;
  localparam int BP_XLEN     = 32;

  // ALU_Control branch opcodes decoded upstream into ex_is_branch
  localparam logic [3:0] ALU_BEQ  = 4'd10;
  localparam logic [3:0] ALU_BNE  = 4'd11;
  localparam logic [3:0] ALU_BLT  = 4'd12;
  localparam logic [3:0] ALU_BGE  = 4'd13;
  localparam logic [3:0] ALU_BLTU = 4'd14;
  localparam logic [3:0] ALU_BGEU = 4'd15;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bp_state_e;

  function automatic logic is_branch_op(input logic [3:0] op);
    return (op == ALU_BEQ) || (op == ALU_BNE) || (op == ALU_BLT) ||
           (op == ALU_BGE) || (op == ALU_BLTU) || (op == ALU_BGEU);
  endfunction

endpackage

// File: rtl/branch_predict_resolve_if.sv
// rtl/branch_predict_resolve_if.sv - fetch/execute/redirect bundle for the predictor (stats ports under BP_STATS_EN)
interface branch_predict_resolve_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] if_pc;
  logic            if_pred_taken;
  logic            bp_ready;
  logic            ex_valid;
  logic            ex_is_branch;
  logic [XLEN-1:0] ex_pc;
  logic            ex_taken;
  logic            ex_pred_taken;
  logic [XLEN-1:0] ex_target;
  logic            flush;
  logic [XLEN-1:0] redirect_pc;
`ifdef BP_STATS_EN
  logic [31:0]     stat_branches;
  logic [31:0]     stat_mispredicts;

  modport master (
    output if_pc, ex_valid, ex_is_branch, ex_pc, ex_taken, ex_pred_taken, ex_target,
    input  if_pred_taken, bp_ready, flush, redirect_pc, stat_branches, stat_mispredicts
  );
  modport slave (
    input  if_pc, ex_valid, ex_is_branch, ex_pc, ex_taken, ex_pred_taken, ex_target,
    output if_pred_taken, bp_ready, flush, redirect_pc, stat_branches, stat_mispredicts
  );
`else
  modport master (
    output if_pc, ex_valid, ex_is_branch, ex_pc, ex_taken, ex_pred_taken, ex_target,
    input  if_pred_taken, bp_ready, flush, redirect_pc
  );
  modport slave (
    input  if_pc, ex_valid, ex_is_branch, ex_pc, ex_taken, ex_pred_taken, ex_target,
    output if_pred_taken, bp_ready, flush, redirect_pc
  );
`endif
endinterface

// File: rtl/bp_sat_counter2.sv
// rtl/bp_sat_counter2.sv - next value of a 2-bit saturating counter given the resolved direction
module bp_sat_counter2
  import branch_predict_resolve_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] next
);

  always_comb begin
    next = ctr;
    if (taken) begin
      if (ctr != ST) next = ctr + 2'd1;
    end else begin
      if (ctr != SNT) next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predict_resolve.sv
// rtl/branch_predict_resolve.sv - bimodal BHT with init sweep and registered mispredict flush; BP_STATS_EN adds counters
module branch_predict_resolve
  import branch_predict_resolve_pkg::*;
#(
  parameter int IDX_BITS = BP_IDX_BITS,
  parameter int XLEN     = BP_XLEN
) (
  input  logic                     clk,
  input  logic                     rst_n,
  branch_predict_resolve_if.slave  bus
);

  localparam int ENTRIES = 1 << IDX_BITS;

  bp_state_e           state_q, state_d;
  logic [IDX_BITS-1:0] idx_cnt;
  logic                init_we;
  logic                run;
  logic [1:0]          bht [ENTRIES];
  logic [IDX_BITS-1:0] if_idx;
  logic [IDX_BITS-1:0] ex_idx;
  logic                upd;
  logic                mis;
  logic [1:0]          ctr_next;
  logic                unused_if_pc;

  assign if_idx       = bus.if_pc[IDX_BITS+1:2];
  assign ex_idx       = bus.ex_pc[IDX_BITS+1:2];
  assign unused_if_pc = ^{bus.if_pc[XLEN-1:IDX_BITS+2], bus.if_pc[1:0]};

  assign upd = bus.ex_valid & bus.ex_is_branch;
  assign mis = upd & (bus.ex_taken != bus.ex_pred_taken);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    init_we = 1'b0;
    run     = 1'b0;
    case (state_q)
      INIT: begin
        init_we = 1'b1;
        if (idx_cnt == {IDX_BITS{1'b1}}) state_d = RUN;
      end
      RUN: run = 1'b1;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)       idx_cnt <= '0;
    else if (init_we) idx_cnt <= idx_cnt + 1'b1;
  end

  bp_sat_counter2 u_sat (
    .ctr   (bht[ex_idx]),
    .taken (bus.ex_taken),
    .next  (ctr_next)
  );

  // Table holds no reset; the INIT sweep rewrites every entry before predictions are exposed.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (init_we)          bht[idx_cnt] <= WNT;
      else if (run && upd)  bht[ex_idx]  <= ctr_next;
    end
  end

  // Read-before-write: the lookup sees the stored value, the update lands on the edge.
  assign bus.if_pred_taken = run & bht[if_idx][1];
  assign bus.bp_ready      = run;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.flush       <= 1'b0;
      bus.redirect_pc <= '0;
    end else begin
      bus.flush <= mis;
      if (mis) bus.redirect_pc <= bus.ex_taken ? bus.ex_target : bus.ex_pc + XLEN'(4);
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.stat_branches    <= '0;
      bus.stat_mispredicts <= '0;
    end else begin
      if (upd) bus.stat_branches    <= bus.stat_branches + 32'd1;
      if (mis) bus.stat_mispredicts <= bus.stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predict_resolve.sv
// tb/tb_branch_predict_resolve.sv - scoreboard bench for branch_predict_resolve (BP_STATS_EN checks stats)
module tb_branch_predict_resolve;

  typedef struct {
    int          due;
    logic [31:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   exp_br = 0;
  int   exp_mis = 0;
  exp_t exp_q[$];

  branch_predict_resolve_if #(.XLEN(32)) bus ();

  branch_predict_resolve #(.IDX_BITS(6), .XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every cycle flush must match the scoreboard exactly.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      n_tests++;
      n_fail++;
      $display("FAIL missed_flush: got none, expected redirect 0x%0h at cycle %0d", exp_q[0].pc, exp_q[0].due);
      void'(exp_q.pop_front());
    end
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      check("flush", bus.flush, 1);
      check("redirect_pc", bus.redirect_pc, exp_q[0].pc);
      void'(exp_q.pop_front());
    end else begin
      check("no_flush", bus.flush, 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic b, input logic [31:0] pc,
                       input logic t, input logic p, input logic [31:0] tgt);
    exp_t e;
    bus.ex_valid      = v;
    bus.ex_is_branch  = b;
    bus.ex_pc         = pc;
    bus.ex_taken      = t;
    bus.ex_pred_taken = p;
    bus.ex_target     = tgt;
    if (v && b) begin
      exp_br++;
      if (t != p) begin
        exp_mis++;
        e.due = cyc + 1;
        e.pc  = t ? tgt : pc + 32'd4;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic idle();
    bus.ex_valid     = 1'b0;
    bus.ex_is_branch = 1'b0;
  endtask

  task automatic init_sweep(input logic with_init_mis);
    for (int k = 1; k <= 64; k++) begin
      bus.if_pc = 32'(k * 4);
      if (with_init_mis && k == 30) drive(1, 1, 32'h300, 1, 0, 32'h500);
      step();
      if (with_init_mis && k == 30) idle();
      check("bp_ready_init", bus.bp_ready, (k == 64) ? 1 : 0);
      if (k < 64) check("pred_init", bus.if_pred_taken, 0);
    end
  endtask

  task automatic check_stats();
`ifdef BP_STATS_EN
    check("stat_branches", bus.stat_branches, exp_br);
    check("stat_mispredicts", bus.stat_mispredicts, exp_mis);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bus.if_pc = '0;
    bus.ex_pc = '0;
    bus.ex_target = '0;
    bus.ex_taken = 1'b0;
    bus.ex_pred_taken = 1'b0;
    idle();
    step();
    step();
    rst_n = 1'b1;
    check("bp_ready_reset", bus.bp_ready, 0);
    check_stats();

    // Init sweep with a mispredict at k=30: flush fires, table update dropped.
    init_sweep(1'b1);
    for (int i = 0; i < 64; i++) begin
      bus.if_pc = 32'(i * 4);
      #1;
      check("pred_all_wnt", bus.if_pred_taken, 0);
    end
    bus.if_pc = 32'h300;
    #1;
    check("pred_init_drop", bus.if_pred_taken, 0);

    step();
    drive(1, 1, 32'h100, 1, 0, 32'h80);
    step();
    idle();
    bus.if_pc = 32'h100;
    #1;
    check("pred_after_taken", bus.if_pred_taken, 1);

    // Saturation: 01->10->11->11->10->01 at pc 0x10.
    step();
    bus.if_pc = 32'h10;
    drive(1, 1, 32'h10, 1, 0, 32'h900); step(); check("sat_u1", bus.if_pred_taken, 1);
    drive(1, 1, 32'h10, 1, 1, 32'h900); step(); check("sat_u2", bus.if_pred_taken, 1);
    drive(1, 1, 32'h10, 1, 1, 32'h900); step(); check("sat_u3", bus.if_pred_taken, 1);
    drive(1, 1, 32'h10, 0, 1, 32'h900); step(); check("sat_u4", bus.if_pred_taken, 1);
    drive(1, 1, 32'h10, 0, 1, 32'h900); step(); check("sat_u5", bus.if_pred_taken, 0);
    idle();

    // Back-to-back fall-through redirects including address wrap.
    step();
    drive(1, 1, 32'h200, 0, 1, 32'h4000);
    step();
    drive(1, 1, 32'hFFFF_FFFC, 0, 1, 32'h4000);
    step();
    idle();

    // Non-branch and invalid slots: no flush, no table change.
    step();
    drive(1, 0, 32'h20, 1, 0, 32'h9999);
    step();
    drive(0, 1, 32'h20, 1, 0, 32'h9999);
    step();
    idle();
    bus.if_pc = 32'h20;
    #1;
    check("pred_nonbranch", bus.if_pred_taken, 0);

    // Same-cycle read and write of index 16.
    step();
    bus.if_pc = 32'h40;
    drive(1, 1, 32'h40, 1, 0, 32'h1000);
    #1;
    check("rbw_same_cycle", bus.if_pred_taken, 0);
    step();
    idle();
    check("rbw_next_cycle", bus.if_pred_taken, 1);
    step();
    check_stats();

    // Reset while a mispredict is pending: flush must stay low.
    bus.ex_valid = 1'b1;
    bus.ex_is_branch = 1'b1;
    bus.ex_pc = 32'h40;
    bus.ex_taken = 1'b1;
    bus.ex_pred_taken = 1'b0;
    bus.ex_target = 32'h7000;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    idle();
    exp_br = 0;
    exp_mis = 0;
    check("flush_after_reset", bus.flush, 0);
    check("bp_ready_after_reset", bus.bp_ready, 0);
    check_stats();
    init_sweep(1'b0);
    bus.if_pc = 32'h40;
    #1;
    check("pred_reinit", bus.if_pred_taken, 0);

    step();
    drive(1, 1, 32'h80, 1, 1, 32'h800); step();
    drive(1, 1, 32'h80, 1, 0, 32'h800); step();
    drive(1, 1, 32'h84, 0, 0, 32'h800); step();
    drive(1, 1, 32'h88, 0, 1, 32'h800); step();
    drive(1, 1, 32'h8C, 1, 1, 32'h800); step();
    idle();
    step();
    step();
    check_stats();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
